// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the SPI-driven overlay control register file.
// Holds register address map, special command bytes, FSM state encoding
// and the command validity helper used by the decoder.
package pipeline_ctrl_pkg;

    // Per-layer register addresses (command bits 3:0)
    localparam logic [3:0] ADDR_MODE         = 4'd0;
    localparam logic [3:0] ADDR_SCALE        = 4'd1;
    localparam logic [3:0] ADDR_OFFSET_X     = 4'd2;
    localparam logic [3:0] ADDR_OFFSET_Y     = 4'd3;
    localparam logic [3:0] ADDR_CLIP_LEFT    = 4'd4;
    localparam logic [3:0] ADDR_CLIP_RIGHT   = 4'd5;
    localparam logic [3:0] ADDR_CLIP_TOP     = 4'd6;
    localparam logic [3:0] ADDR_CLIP_BOTTOM  = 4'd7;
    localparam logic [3:0] ADDR_TRANSPARENCY = 4'd8;
    localparam logic [3:0] ADDR_FREEZE       = 4'd9;
    localparam logic [3:0] ADDR_RSVD_LO      = 4'd10;
    localparam logic [3:0] ADDR_RSVD_HI      = 4'd14;

    // Special command bytes
    localparam logic [7:0] CMD_RESET  = 8'h0F;
    localparam logic [7:0] CMD_STATUS = 8'h8F;
    localparam logic [7:0] CMD_NOP    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_HI = 3'd1,
        ST_WR_LO = 3'd2,
        ST_APPLY = 3'd3,
        ST_RD_HI = 3'd4,
        ST_RD_LO = 3'd5
    } state_t;

    // A command is valid when it names an existing layer and a
    // non-reserved address.
    function automatic logic cmd_is_valid(input logic [2:0] layer,
                                          input logic [3:0] addr,
                                          input int num_layers);
        return (int'(layer) < num_layers) &&
               !(addr >= ADDR_RSVD_LO && addr <= ADDR_RSVD_HI);
    endfunction

endpackage

// File: rtl/layer_regs.sv
// One overlay layer's double-buffered register set.
// Ports: clk/rst_n; write port (we, addr, wdata) and clr update the shadow
// set; commit copies shadow to active; rd_addr/rd_data read back the active
// set (offsets sign-extended); the remaining outputs are the active values.
module layer_regs
    import pipeline_ctrl_pkg::*;
#(
    parameter int PRECISION              = 11,
    parameter int TRANSPARENCY_PRECISION = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic                              clr,
    input  logic [3:0]                        addr,
    input  logic [15:0]                       wdata,
    input  logic                              commit,
    input  logic [3:0]                        rd_addr,
    output logic [15:0]                       rd_data,
    output logic [1:0]                        mode,
    output logic [1:0]                        scale,
    output logic [PRECISION:0]                offset_x,
    output logic [PRECISION:0]                offset_y,
    output logic [PRECISION-1:0]              clip_left,
    output logic [PRECISION-1:0]              clip_right,
    output logic [PRECISION-1:0]              clip_top,
    output logic [PRECISION-1:0]              clip_bottom,
    output logic [TRANSPARENCY_PRECISION-1:0] transparency,
    output logic                              freeze
);
    localparam int P = PRECISION;
    localparam int T = TRANSPARENCY_PRECISION;

    logic [1:0]   s_mode, s_scale;
    logic [P:0]   s_offx, s_offy;
    logic [P-1:0] s_cl, s_cr, s_ct, s_cb;
    logic [T-1:0] s_tr;
    logic         s_frz;

    // Upper word bits beyond the widest register are simply truncated.
    logic unused_wdata;
    assign unused_wdata = ^wdata[15:P+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_mode <= '0; s_scale <= '0; s_offx <= '0; s_offy <= '0;
            s_cl <= '0; s_cr <= '0; s_ct <= '0; s_cb <= '0;
            s_tr <= '0; s_frz <= 1'b0;
            mode <= '0; scale <= '0; offset_x <= '0; offset_y <= '0;
            clip_left <= '0; clip_right <= '0; clip_top <= '0; clip_bottom <= '0;
            transparency <= '0; freeze <= 1'b0;
        end else begin
            if (clr) begin
                s_mode <= '0; s_scale <= '0; s_offx <= '0; s_offy <= '0;
                s_cl <= '0; s_cr <= '0; s_ct <= '0; s_cb <= '0;
                s_tr <= '0; s_frz <= 1'b0;
            end else if (we) begin
                case (addr)
                    ADDR_MODE:         s_mode  <= wdata[1:0];
                    ADDR_SCALE:        s_scale <= wdata[1:0];
                    ADDR_OFFSET_X:     s_offx  <= wdata[P:0];
                    ADDR_OFFSET_Y:     s_offy  <= wdata[P:0];
                    ADDR_CLIP_LEFT:    s_cl    <= wdata[P-1:0];
                    ADDR_CLIP_RIGHT:   s_cr    <= wdata[P-1:0];
                    ADDR_CLIP_TOP:     s_ct    <= wdata[P-1:0];
                    ADDR_CLIP_BOTTOM:  s_cb    <= wdata[P-1:0];
                    ADDR_TRANSPARENCY: s_tr    <= wdata[T-1:0];
                    ADDR_FREEZE:       s_frz   <= wdata[0];
                    default: ;
                endcase
            end
            // Commit samples the shadow before any same-cycle write lands.
            if (commit) begin
                mode <= s_mode; scale <= s_scale;
                offset_x <= s_offx; offset_y <= s_offy;
                clip_left <= s_cl; clip_right <= s_cr;
                clip_top <= s_ct; clip_bottom <= s_cb;
                transparency <= s_tr; freeze <= s_frz;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_MODE:         rd_data = 16'(mode);
            ADDR_SCALE:        rd_data = 16'(scale);
            ADDR_OFFSET_X:     rd_data = {{(15-P){offset_x[P]}}, offset_x};
            ADDR_OFFSET_Y:     rd_data = {{(15-P){offset_y[P]}}, offset_y};
            ADDR_CLIP_LEFT:    rd_data = 16'(clip_left);
            ADDR_CLIP_RIGHT:   rd_data = 16'(clip_right);
            ADDR_CLIP_TOP:     rd_data = 16'(clip_top);
            ADDR_CLIP_BOTTOM:  rd_data = 16'(clip_bottom);
            ADDR_TRANSPARENCY: rd_data = 16'(transparency);
            ADDR_FREEZE:       rd_data = 16'(freeze);
            default:           rd_data = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_spi_regfile.sv
// Multi-layer double-buffered control register file fed by SPI bytes.
// Ports: clk/rst_n; spi_active, rx_byte, rx_valid from the SPI slave;
// tx_byte/tx_load reply bytes back to it; frame_sync/commit_hold control the
// shadow-to-active commit; ctrl_* are the packed active registers (layer n
// in slice n); cmd_error is the sticky bad-command flag; dbg_state exposes
// the decoder FSM.
// Handshake: a byte is consumed on any cycle where rx_valid and spi_active
// are both high; tx_load is a one-cycle strobe with no back-pressure.
module pipeline_spi_regfile
    import pipeline_ctrl_pkg::*;
#(
    parameter int PRECISION              = 11,
    parameter int TRANSPARENCY_PRECISION = 3,
    parameter int NUM_LAYERS             = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         spi_active,
    input  logic [7:0]                                   rx_byte,
    input  logic                                         rx_valid,
    output logic [7:0]                                   tx_byte,
    output logic                                         tx_load,
    input  logic                                         frame_sync,
    input  logic                                         commit_hold,
    output logic [2*NUM_LAYERS-1:0]                      ctrl_overlay_mode,
    output logic [2*NUM_LAYERS-1:0]                      ctrl_fg_scale,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_x,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_y,
    output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_left,
    output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_right,
    output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_top,
    output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_bottom,
    output logic [TRANSPARENCY_PRECISION*NUM_LAYERS-1:0] ctrl_fg_transparency,
    output logic [NUM_LAYERS-1:0]                        ctrl_fg_freeze,
    output logic                                         cmd_error,
    output state_t                                       dbg_state
);
    localparam int P  = PRECISION;
    localparam int T  = TRANSPARENCY_PRECISION;
    localparam int NL = NUM_LAYERS;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, data_hi_q, data_lo_q, rd_lo_q;
    logic [15:0] layer_rd [NL];
    logic [15:0] rd_sel;
    logic        rx_ok, rx_special, apply_we, apply_clr, commit;

    assign rx_ok      = rx_valid & spi_active;
    assign rx_special = (rx_byte == CMD_RESET) || (rx_byte == CMD_STATUS) ||
                        (rx_byte == CMD_NOP);
    assign commit     = frame_sync & ~commit_hold;
    assign dbg_state  = state_q;

    // Readback is taken from the command byte itself so the high reply byte
    // can be loaded the cycle after the command arrives.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NL; i++) begin
            if (rx_byte[6:4] == 3'(i)) rd_sel = layer_rd[i];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state. Losing slave select aborts any frame; APPLY needs no
    // guard because its write is unconditional and it always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!spi_active) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (rx_valid) begin
                    if (rx_byte == CMD_RESET)     state_d = ST_APPLY;
                    else if (rx_byte == CMD_NOP)  state_d = ST_IDLE;
                    else if (rx_byte[7])          state_d = ST_RD_HI;
                    else                          state_d = ST_WR_HI;
                end
                ST_WR_HI: if (rx_valid) state_d = ST_WR_LO;
                ST_WR_LO: if (rx_valid) state_d = ST_APPLY;
                ST_APPLY:               state_d = ST_IDLE;
                ST_RD_HI: if (rx_valid) state_d = ST_RD_LO;
                ST_RD_LO: if (rx_valid) state_d = ST_IDLE;
                default:                state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        apply_clr = (state_q == ST_APPLY) && (cmd_q == CMD_RESET);
        apply_we  = (state_q == ST_APPLY) && (cmd_q != CMD_RESET) &&
                    cmd_is_valid(cmd_q[6:4], cmd_q[3:0], NL);
    end

    // Command/data capture, error flag and reply sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            data_hi_q <= '0;
            data_lo_q <= '0;
            rd_lo_q   <= '0;
            tx_byte   <= '0;
            tx_load   <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            case (state_q)
                ST_IDLE: if (rx_ok) begin
                    cmd_q <= rx_byte;
                    if (rx_byte == CMD_STATUS) begin
                        // Reply carries the flag value from before the clear.
                        cmd_error <= 1'b0;
                        tx_byte   <= {7'b0, cmd_error};
                        rd_lo_q   <= 8'h00;
                        tx_load   <= 1'b1;
                    end else if (!rx_special) begin
                        if (!cmd_is_valid(rx_byte[6:4], rx_byte[3:0], NL))
                            cmd_error <= 1'b1;
                        if (rx_byte[7]) begin
                            tx_byte <= rd_sel[15:8];
                            rd_lo_q <= rd_sel[7:0];
                            tx_load <= 1'b1;
                        end
                    end
                end
                ST_WR_HI: if (rx_ok) data_hi_q <= rx_byte;
                ST_WR_LO: if (rx_ok) data_lo_q <= rx_byte;
                ST_RD_HI: if (rx_ok) begin
                    tx_byte <= rd_lo_q;
                    tx_load <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NL; g++) begin : g_layer
        layer_regs #(
            .PRECISION             (P),
            .TRANSPARENCY_PRECISION(T)
        ) u_regs (
            .clk         (clk),
            .rst_n       (rst_n),
            .we          (apply_we && (cmd_q[6:4] == 3'(g))),
            .clr         (apply_clr),
            .addr        (cmd_q[3:0]),
            .wdata       ({data_hi_q, data_lo_q}),
            .commit      (commit),
            .rd_addr     (rx_byte[3:0]),
            .rd_data     (layer_rd[g]),
            .mode        (ctrl_overlay_mode[2*g +: 2]),
            .scale       (ctrl_fg_scale[2*g +: 2]),
            .offset_x    (ctrl_fg_offset_x[(P+1)*g +: P+1]),
            .offset_y    (ctrl_fg_offset_y[(P+1)*g +: P+1]),
            .clip_left   (ctrl_fg_clip_left[P*g +: P]),
            .clip_right  (ctrl_fg_clip_right[P*g +: P]),
            .clip_top    (ctrl_fg_clip_top[P*g +: P]),
            .clip_bottom (ctrl_fg_clip_bottom[P*g +: P]),
            .transparency(ctrl_fg_transparency[T*g +: T]),
            .freeze      (ctrl_fg_freeze[g])
        );
    end

endmodule
